// File: rtl/bram_fifo_ctrl_if.sv
// Valid/ready word stream. The producer uses master, the consumer uses slave.
interface bram_fifo_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/bram_fifo_ctrl.sv
// Stream FIFO controller around a true dual-port BRAM: port A writes, port B prefetches
// into a 2-entry output stage. Optional sticky ovf/udf flags under BRAM_FIFO_FLAGS_EN.
module bram_fifo_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  bram_fifo_ctrl_if.slave   s,
  bram_fifo_ctrl_if.master  m,
  output logic [ADDR_W+1:0] level,
  output logic              wrena,
  output logic              rdena,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              wrenb,
  output logic              rdenb,
  output logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] dinb,
  input  logic [DATA_W-1:0] doutb,
  output logic              ovf,
  output logic              udf,
  input  logic              clr_flags
);
  localparam int PW = ADDR_W + 1;
  localparam int LW = ADDR_W + 2;

  logic [ADDR_W:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                        alive_q;
  logic                        inflight_q, inflight_d;
  logic [1:0]                  stage_cnt_q, stage_cnt_d;
  logic [1:0][DATA_W-1:0]      stage_q, stage_d;
  logic [LW-1:0]               level_q, level_d;
  logic                        mem_full, mem_empty, wr_acc, pop, rd_iss;
  logic [1:0]                  base;

  // Full/empty come from registered pointers only, so a read never targets a slot
  // written this cycle and a freed slot is not rewritten in its read-issue cycle.
  assign mem_empty = (wr_ptr_q == rd_ptr_q);
  assign mem_full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                     (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

  assign s.ready = alive_q & ~mem_full;
  assign m.valid = (stage_cnt_q != 2'd0);
  assign m.data  = stage_q[0];

  assign wr_acc = s.valid & s.ready;
  assign pop    = m.valid & m.ready;
  assign rd_iss = ~mem_empty & ((({1'b0, stage_cnt_q} + {2'b00, inflight_q}) < 3'd2) | pop);

  assign wrena = wr_acc;
  assign addra = wr_ptr_q[ADDR_W-1:0];
  assign dina  = s.data;
  assign rdena = 1'b0;
  assign wrenb = 1'b0;
  assign rdenb = rd_iss;
  assign addrb = rd_ptr_q[ADDR_W-1:0];
  assign dinb  = '0;
  assign level = level_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d   = rd_ptr_q + PW'(rd_iss);
    inflight_d = rd_iss;
    level_d    = level_q + LW'(wr_acc) - LW'(pop);
    stage_d    = stage_q;
    // Pop shifts the pair first; returning BRAM data lands behind whatever remains.
    base       = stage_cnt_q - {1'b0, pop};
    if (pop) stage_d[0] = stage_q[1];
    if (inflight_q) stage_d[base[0]] = doutb;
    stage_cnt_d = base + {1'b0, inflight_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      alive_q     <= 1'b0;
      inflight_q  <= 1'b0;
      stage_cnt_q <= 2'd0;
      stage_q     <= '0;
      level_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      alive_q     <= 1'b1;
      inflight_q  <= inflight_d;
      stage_cnt_q <= stage_cnt_d;
      stage_q     <= stage_d;
      level_q     <= level_d;
    end
  end

`ifdef BRAM_FIFO_FLAGS_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  // A set condition in the same cycle as clr_flags wins.
  always_comb begin
    ovf_d = clr_flags ? 1'b0 : ovf_q;
    udf_d = clr_flags ? 1'b0 : udf_q;
    if (s.valid & ~s.ready) ovf_d = 1'b1;
    if (m.ready & ~m.valid) udf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`else
  logic unused_clr_flags;
  assign unused_clr_flags = clr_flags;
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed bench for bram_fifo_ctrl with a behavioural 1024x16 BRAM and a data scoreboard.
module tb_bram_fifo_ctrl;
  localparam int AW    = 10;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;
`ifdef BRAM_FIFO_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW+1:0] level;
  logic          wrena, rdena, wrenb, rdenb, ovf, udf, clr_flags;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dina, dinb, doutb;

  bram_fifo_ctrl_if #(.DATA_W(DW)) s_if ();
  bram_fifo_ctrl_if #(.DATA_W(DW)) m_if ();

  always #5 clk = ~clk;

  bram_fifo_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .s(s_if), .m(m_if), .level(level),
    .wrena(wrena), .rdena(rdena), .addra(addra), .dina(dina),
    .wrenb(wrenb), .rdenb(rdenb), .addrb(addrb), .dinb(dinb),
    .doutb(doutb), .ovf(ovf), .udf(udf), .clr_flags(clr_flags)
  );

  // Behavioural BRAM: registered read on port B, write on port A.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (wrena) mem[addra] <= dina;
    if (rdenb) doutb <= mem[addrb];
  end

  int            n_vec = 0;
  int            n_err = 0;
  int            rx_cnt = 0;
  logic [DW-1:0] exp_q [$];
  bit            mon_on = 0;
  bit            gap_chk = 0;
  bit            seen_v = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Push one word per accepted handshake, waiting (bounded) for s_ready.
  task automatic write_n(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      s_if.data  = base + DW'(i);
      s_if.valid = 1'b1;
      while (!s_if.ready && k < 100) begin cyc(1); k++; end
      if (k >= 100) chk("write_timeout", k, 0);
      cyc(1);
    end
    s_if.valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    m_if.ready = 1'b1;
    while ((exp_q.size() != 0 || m_if.valid) && k < budget) begin cyc(1); k++; end
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_level0"}, level, 0);
  endtask

  // Monitor: sampled on the falling edge, where this cycle's handshakes are settled.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_stall = 0;
      seen_v     = 0;
    end else if (mon_on) begin
      chk("bram_unused_zero", {wrenb, rdena, dinb}, 0);
      if (prev_stall) begin
        chk("stall_valid", m_if.valid, 1);
        chk("stall_data", m_if.data, prev_data);
      end
      if (gap_chk) begin
        if (m_if.valid) seen_v = 1;
        else if (seen_v && exp_q.size() != 0) chk("stream_no_gap", m_if.valid, 1);
        chk("stream_level_le3", level <= 3, 1);
      end
      if (m_if.valid && m_if.ready) begin
        if (exp_q.size() == 0) chk("spurious_pop", exp_q.size(), 1);
        else chk("pop_data", m_if.data, exp_q.pop_front());
        rx_cnt++;
      end
      if (s_if.valid && s_if.ready) exp_q.push_back(s_if.data);
      prev_stall = m_if.valid & ~m_if.ready;
      prev_data  = m_if.data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rx0, k, target;
    s_if.valid = 1'b0; s_if.data = '0; m_if.ready = 1'b0; clr_flags = 1'b0;
    cyc(3);
    chk("rst_s_ready", s_if.ready, 0);
    chk("rst_m_valid", m_if.valid, 0);
    chk("rst_m_data", m_if.data, 0);
    chk("rst_level", level, 0);
    chk("rst_flags", {ovf, udf}, 0);
    chk("rst_rdenb", rdenb, 0);
    rst_n = 1'b1;
    cyc(1);
    chk("s_ready_after_rst", s_if.ready, 1);
    mon_on = 1;

    // Underflow flag and clear
    m_if.ready = 1'b1;
    cyc(1);
    chk("udf_set", udf, FL);
    m_if.ready = 1'b0; clr_flags = 1'b1;
    cyc(1);
    clr_flags = 1'b0;
    chk("udf_cleared", udf, 0);

    // Single word latency
    m_if.ready = 1'b1; s_if.valid = 1'b1; s_if.data = 16'h00FF;
    cyc(1);
    s_if.valid = 1'b0;
    chk("lat_e0_valid", m_if.valid, 0);
    chk("lat_e0_level", level, 1);
    cyc(1);
    chk("lat_e1_valid", m_if.valid, 0);
    cyc(1);
    chk("lat_e2_valid", m_if.valid, 1);
    chk("lat_e2_data", m_if.data, 16'h00FF);
    cyc(1);
    chk("single_level0", level, 0);
    chk("single_valid0", m_if.valid, 0);

    // Streaming 0..99 at full rate
    rx0 = rx_cnt; gap_chk = 1;
    for (int i = 0; i < 100; i++) begin
      s_if.valid = 1'b1; s_if.data = DW'(i);
      chk("stream_s_ready", s_if.ready, 1);
      cyc(1);
    end
    s_if.valid = 1'b0;
    drain("stream", 50);
    gap_chk = 0;
    chk("stream_count", rx_cnt - rx0, 100);

    // Fill to capacity with the consumer stalled
    m_if.ready = 1'b0;
    write_n(1026, 16'h4000);
    cyc(2);
    chk("fill_level", level, 1026);
    chk("fill_s_ready", s_if.ready, 0);
    chk("fill_wrena", wrena, 0);
    chk("fill_head", m_if.data, 16'h4000);
    s_if.valid = 1'b1; s_if.data = 16'hDEAD;
    cyc(1);
    s_if.valid = 1'b0;
    chk("ovf_set", ovf, FL);
    chk("ovf_level_held", level, 1026);
    clr_flags = 1'b1;
    cyc(1);
    clr_flags = 1'b0;
    chk("ovf_cleared", ovf, 0);

    // Partial drain, refill across the pointer wrap, full drain
    target = rx_cnt + 600; k = 0;
    m_if.ready = 1'b1;
    while (rx_cnt < target && k < 2000) begin cyc(1); k++; end
    m_if.ready = 1'b0;
    chk("drain600_count", rx_cnt, target);
    chk("drain600_level", level, 426);
    write_n(600, 16'h8000);
    chk("refill_level", level, 1026);
    drain("wrap", 3000);

    // Backpressure: consumer toggles every cycle
    rx0 = rx_cnt;
    for (int i = 0; i < 60; i++) begin
      s_if.valid = 1'b1; s_if.data = 16'hC000 + DW'(i);
      m_if.ready = ~m_if.ready;
      cyc(1);
    end
    s_if.valid = 1'b0;
    drain("bp", 200);
    chk("bp_count", rx_cnt - rx0, 60);

    // Reset in the middle of a stream with a read in flight
    m_if.ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_if.valid = 1'b1; s_if.data = 16'h5000 + DW'(i);
      cyc(1);
    end
    k = 0;
    while (!rdenb && k < 20) begin cyc(1); k++; end
    chk("pre_rst_rdenb", rdenb, 1);
    cyc(1);
    chk("pre_rst_valid", m_if.valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", m_if.valid, 0);
    chk("midrst_level", level, 0);
    chk("midrst_s_ready", s_if.ready, 0);
    chk("midrst_m_data", m_if.data, 0);
    exp_q.delete();
    s_if.valid = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("post_rst_s_ready", s_if.ready, 1);
    rx0 = rx_cnt;
    write_n(1, 16'h00AA);
    drain("post_rst", 20);
    cyc(5);
    chk("post_rst_count", rx_cnt - rx0, 1);
    chk("post_rst_idle", m_if.valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
